// File: rtl/rom_frame_reader.sv
// rom_frame_reader: raster-scan reader for a single-port synchronous image ROM.
// The pixels leave as a valid/ready stream tagged with sof/eol/eof. The ROM read
// latency is hidden behind a small credit-limited FIFO with registered outputs.
// The first pixel appears RD_LATENCY+2 cycles after the cycle in which frame_start
// is accepted. Backpressure stalls address issue through the credit check, so no
// pixel is lost or repeated.
// Optional macro ROM_FRAME_READER_LOOP_EN: streams frames back to back without end
// after the first frame_start.

module rom_frame_reader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 24,
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256,
  parameter int BASE_ADDR  = 0,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  output logic                  busy,
  output logic                  frame_done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof
);

  // Credit covers one entry per ROM latency stage, plus the head entry, plus one
  // entry of slack. This sustains one pixel per clock with m_ready held high.
  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int XW         = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW         = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int EW         = DATA_WIDTH + 3;

  localparam logic [ADDR_WIDTH-1:0] BASE   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [XW-1:0]         X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0]         Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;

  logic [RD_LATENCY-1:0] pipe_vld_q;
  logic [2:0]            pipe_flg_q [RD_LATENCY];

  logic [EW-1:0]         fifo_q [FIFO_DEPTH];
  logic [EW-1:0]         fifo_d [FIFO_DEPTH];
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0]      wr_idx;
  logic [CNT_W-1:0]      inflight;

  logic                  frame_done_q;

  logic                  accept;
  logic                  credit_ok;
  logic                  issue;
  logic                  x_last, y_last, frame_last;
  logic [2:0]            issue_flg;
  logic                  push, pop;
  logic [EW-1:0]         push_word;
  logic                  eof_hs;

  assign x_last     = (x_q == X_LAST);
  assign y_last     = (y_q == Y_LAST);
  assign frame_last = x_last && y_last;

  // The flags are computed at issue time and carried next to the ROM data.
  assign issue_flg  = {(x_q == '0) && (y_q == '0), x_last, frame_last};

  assign accept     = (state_q == IDLE) && frame_start;
  assign issue      = (state_q == ISSUE) && credit_ok;

  assign push       = pipe_vld_q[RD_LATENCY-1];
  assign push_word  = {rom_rd_data, pipe_flg_q[RD_LATENCY-1]};
  assign pop        = m_valid && m_ready;
  assign eof_hs     = pop && m_eof;

  // Count the issues that are still waiting for ROM data.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CNT_W'(pipe_vld_q[i]);
    end
  end

  // Issue only when every outstanding read already has a FIFO slot reserved.
  assign credit_ok = (int'(fifo_cnt_q) + int'(inflight) + 1) <= FIFO_DEPTH;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state. In loop mode ISSUE never ends, so the frame sequence is continuous.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
`ifndef ROM_FRAME_READER_LOOP_EN
        if (issue && frame_last) begin
          state_d = DRAIN;
        end
`endif
      end
      DRAIN: begin
        if (eof_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Raster counters and running ROM address. The address increments by one per
  // issue, so no multiply is needed.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    rom_addr_d = rom_addr_q;
    if (accept) begin
      x_d        = '0;
      y_d        = '0;
      rom_addr_d = BASE;
    end else if (issue) begin
      rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
      if (x_last) begin
        x_d = '0;
        if (y_last) begin
          y_d = '0;
`ifdef ROM_FRAME_READER_LOOP_EN
          rom_addr_d = BASE;
`endif
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  // Counter and address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      rom_addr_q <= BASE;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  // Issue pipe: a valid bit and flags delayed to line up with the ROM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_flg_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= issue;
      pipe_flg_q[0] <= issue_flg;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_flg_q[i] <= pipe_flg_q[i-1];
      end
    end
  end

  // Shift-register FIFO next state. Entry 0 is the head and drives the outputs
  // directly. A pop shifts zeros in from the top, so unused entries stay at zero
  // and the outputs read zero when the FIFO is empty.
  always_comb begin
    fifo_d     = fifo_q;
    fifo_cnt_d = fifo_cnt_q;
    wr_idx     = fifo_cnt_q;
    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        fifo_d[i] = fifo_q[i+1];
      end
      fifo_d[FIFO_DEPTH-1] = '0;
      wr_idx = fifo_cnt_q - CNT_W'(1);
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (push && (int'(wr_idx) == i)) begin
        fifo_d[i] = push_word;
      end
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // FIFO storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      fifo_cnt_q <= fifo_cnt_d;
      fifo_q     <= fifo_d;
    end
  end

  // Frame completion pulse, on the cycle after the eof pixel handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= eof_hs;
    end
  end

  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign rom_addr   = rom_addr_q;
  assign m_valid    = (fifo_cnt_q != '0);
  assign m_data     = fifo_q[0][EW-1:3];
  assign m_sof      = fifo_q[0][2];
  assign m_eol      = fifo_q[0][1];
  assign m_eof      = fifo_q[0][0];

  // The credit scheme must make these two conditions unreachable.
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));
  a_inflight_bound: assert property (@(posedge clk) disable iff (!rst_n)
    int'(inflight) <= FIFO_DEPTH);

endmodule

// File: tb/tb_rom_frame_reader.sv
// Directed bench for rom_frame_reader. Instance A reads a 4x2 image with
// RD_LATENCY=1 and BASE_ADDR=0. Instance B reads a 3x3 image with RD_LATENCY=2
// and BASE_ADDR=0x100. Each ROM model returns {8'hA5, addr}.

module tb_rom_frame_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        fs_a, rdy_a, busy_a, done_a, vld_a, sof_a, eol_a, eof_a;
  logic [15:0] addr_a;
  logic [23:0] rd_a, dat_a;

  logic        fs_b, rdy_b, busy_b, done_b, vld_b, sof_b, eol_b, eof_b;
  logic [15:0] addr_b;
  logic [23:0] rd_b, rb1, dat_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // ROM models: a single register for latency 1, two registers for latency 2.
  always @(posedge clk) rd_a <= {8'hA5, addr_a};
  always @(posedge clk) begin
    rb1  <= {8'hA5, addr_b};
    rd_b <= rb1;
  end

  rom_frame_reader #(.ADDR_WIDTH(16), .DATA_WIDTH(24), .IMG_W(4), .IMG_H(2),
                     .BASE_ADDR(0), .RD_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .frame_start(fs_a), .busy(busy_a),
    .frame_done(done_a), .rom_addr(addr_a), .rom_rd_data(rd_a),
    .m_valid(vld_a), .m_ready(rdy_a), .m_data(dat_a),
    .m_sof(sof_a), .m_eol(eol_a), .m_eof(eof_a));

  rom_frame_reader #(.ADDR_WIDTH(16), .DATA_WIDTH(24), .IMG_W(3), .IMG_H(3),
                     .BASE_ADDR(256), .RD_LATENCY(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_start(fs_b), .busy(busy_b),
    .frame_done(done_b), .rom_addr(addr_b), .rom_rd_data(rd_b),
    .m_valid(vld_b), .m_ready(rdy_b), .m_data(dat_b),
    .m_sof(sof_b), .m_eol(eol_b), .m_eof(eof_b));

  function automatic logic [23:0] pix(input int a);
    pix = {8'hA5, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    n_fail++;
    $error("FAIL timeout: bench did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int idx;
    int dn;
    fs_a = 1'b0; rdy_a = 1'b0; fs_b = 1'b0; rdy_b = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_addr_a", addr_a, 16'h0000);
    chk("rst_addr_b", addr_b, 16'h0100);
    chk("rst_valid", vld_a, 1'b0);
    chk("rst_data", dat_a, 24'h000000);
    chk("rst_flags", {sof_a, eol_a, eof_a}, 3'b000);
    #3 rst_n = 1'b1;
    tick;
    tick;

`ifndef ROM_FRAME_READER_LOOP_EN
    // Test 1: basic frame with m_ready=1 and exact cycle timing.
    rdy_a = 1'b1;
    fs_a  = 1'b1;
    tick;
    fs_a  = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      chk("t1_valid", vld_a, (c >= 3 && c <= 10));
      chk("t1_busy", busy_a, (c <= 10));
      chk("t1_done", done_a, (c == 11));
      if (c >= 3 && c <= 10) begin
        chk("t1_data", dat_a, pix(c - 3));
        chk("t1_sof", sof_a, (c == 3));
        chk("t1_eol", eol_a, (c == 6 || c == 10));
        chk("t1_eof", eof_a, (c == 10));
      end
      tick;
    end

    // Test 2: hold m_ready low for 5 cycles starting at pixel 2.
    idx = 0;
    dn  = 0;
    fs_a = 1'b1;
    tick;
    fs_a = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      rdy_a = !(c >= 5 && c <= 9);
      if (c >= 5 && c <= 9) begin
        chk("t2_hold_valid", vld_a, 1'b1);
        chk("t2_hold_data", dat_a, pix(2));
        chk("t2_credit", (addr_a <= 16'd5), 1'b1);
      end
      if (vld_a && rdy_a) begin
        chk("t2_order", dat_a, pix(idx));
        chk("t2_eof", eof_a, (idx == 7));
        idx++;
      end
      if (done_a) dn++;
      tick;
    end
    rdy_a = 1'b1;
    chk("t2_count", idx, 8);
    chk("t2_done_cnt", dn, 1);

    // Test 4: a second frame_start while busy is ignored.
    idx = 0;
    dn  = 0;
    fs_a = 1'b1;
    tick;
    fs_a = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      fs_a = (c == 5);
      if (vld_a && rdy_a) begin
        chk("t4_order", dat_a, pix(idx % 8));
        idx++;
      end
      if (done_a) dn++;
      tick;
    end
    fs_a = 1'b0;
    chk("t4_count", idx, 8);
    chk("t4_done_cnt", dn, 1);
    chk("t4_idle", busy_a, 1'b0);

    // Test 3: RD_LATENCY=2, base 0x100, 3x3 image, m_ready toggling every cycle.
    idx = 0;
    dn  = 0;
    fs_b = 1'b1;
    tick;
    fs_b = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      rdy_b = (c % 2 == 1);
      if (c == 3) chk("t3_lat_lo", vld_b, 1'b0);
      if (c == 4) chk("t3_lat_hi", vld_b, 1'b1);
      if (vld_b && rdy_b) begin
        chk("t3_data", dat_b, pix(256 + idx));
        chk("t3_sof", sof_b, (idx == 0));
        chk("t3_eol", eol_b, (idx % 3 == 2));
        chk("t3_eof", eof_b, (idx == 8));
        idx++;
      end
      if (done_b) dn++;
      tick;
    end
    chk("t3_count", idx, 9);
    chk("t3_done_cnt", dn, 1);

    // Test 5: reset asserted at pixel 4, then a fresh frame.
    rdy_a = 1'b1;
    fs_a  = 1'b1;
    tick;
    fs_a  = 1'b0;
    repeat (6) tick;
    chk("t5_pre_data", dat_a, pix(4));
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", vld_a, 1'b0);
    chk("t5_rst_busy", busy_a, 1'b0);
    chk("t5_rst_addr", addr_a, 16'h0000);
    chk("t5_rst_data", dat_a, 24'h000000);
    #2 rst_n = 1'b1;
    tick;
    fs_a = 1'b1;
    tick;
    fs_a = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) chk("t5_lat_lo", vld_a, 1'b0);
      if (c == 3) begin
        chk("t5_valid", vld_a, 1'b1);
        chk("t5_data", dat_a, pix(0));
        chk("t5_sof", sof_a, 1'b1);
      end
      tick;
    end
`else
    // Loop mode: three 4x2 frames stream back to back without bubbles.
    dn = 0;
    rdy_a = 1'b1;
    fs_a  = 1'b1;
    tick;
    fs_a  = 1'b0;
    for (int c = 1; c <= 27; c++) begin
      chk("lp_valid", vld_a, (c >= 3));
      chk("lp_busy", busy_a, 1'b1);
      chk("lp_done", done_a, (c == 11 || c == 19 || c == 27));
      if (done_a) dn++;
      if (c >= 3) begin
        idx = (c - 3) % 8;
        chk("lp_data", dat_a, pix(idx));
        chk("lp_sof", sof_a, (idx == 0));
        chk("lp_eof", eof_a, (idx == 7));
      end
      tick;
    end
    chk("lp_done_cnt", dn, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_frame_reader.md
Name: rom_frame_reader

Overview:
- Sequences raster-scan reads of a stored image from the single-port synchronous image ROM.
- Emits the pixels as a valid/ready stream with start-of-frame, end-of-line and end-of-frame flags. The stream feeds the erosion/dilation filter and the HDMI pipeline.
- Hides the ROM read latency behind a credit-limited output FIFO, so downstream backpressure never loses or duplicates a pixel.

Parameters:
- ADDR_WIDTH, 16, ROM address width.
- DATA_WIDTH, 24, pixel width (RGB888).
- IMG_W, 256, pixels per line (2..2^ADDR_WIDTH).
- IMG_H, 256, lines per frame. IMG_W*IMG_H + BASE_ADDR must be <= 2^ADDR_WIDTH.
- BASE_ADDR, 0, ROM address of pixel (0,0).
- RD_LATENCY, 1, ROM address-to-data cycles. Legal values are 1 or 2 (2 when the ROM output register is enabled).

Ports:
- clk  in  1  system clock; the ROM shares this clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  single-cycle request to read one frame.
- busy  out  1  high from acceptance of frame_start until the last pixel handshakes.
- frame_done  out  1  one-cycle pulse on the cycle after the last pixel handshakes.
- rom_addr  out  ADDR_WIDTH  registered address to the ROM.
- rom_rd_data  in  DATA_WIDTH  ROM read data.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_WIDTH  pixel.
- m_sof  out  1  marks pixel (0,0); qualified by m_valid.
- m_eol  out  1  marks the last pixel of each line; qualified by m_valid.
- m_eof  out  1  marks the last pixel of the frame; qualified by m_valid.

Behaviour:
- Reset values: busy=0, frame_done=0, rom_addr=BASE_ADDR, m_valid=0, m_data=0, all flags 0. FSM=IDLE; counters, FIFO and issue pipe are cleared.
- Reset mid-frame: everything returns immediately to the reset values and the partial frame is discarded.
- FSM states:
  - IDLE: frame_start goes to ISSUE.
  - ISSUE: moves to DRAIN once the last address (x=IMG_W-1, y=IMG_H-1) has been issued.
  - DRAIN: moves to IDLE on the handshake of the m_eof pixel.
- frame_start is ignored when busy=1.
- Issue counters x (0..IMG_W-1) and y (0..IMG_H-1) reload to 0 on frame acceptance.
  - An issue occurs in ISSUE when credit is available.
  - rom_addr is a running counter: BASE_ADDR on acceptance, incremented by 1 per issue. No multiplier is used.
  - x wraps to 0 at IMG_W-1 and y increments; the last issue ends ISSUE.
- Credit: FIFO_DEPTH = RD_LATENCY+2 entries. An issue is allowed only when fifo_count + inflight + 1 <= FIFO_DEPTH, where inflight is the count of issues still in the latency pipe.
- Issue pipe:
  - A valid bit plus {sof, eol, eof} travels a RD_LATENCY-stage shift register, aligned with the ROM data.
  - When the pipe output is valid, rom_rd_data and its flags are written to the FIFO.
  - rom_rd_data is ignored on all other cycles, and rom_addr holds its value when not issuing.
- FIFO:
  - Registered output; m_valid = FIFO not empty.
  - A push and a pop on the same cycle leave the count unchanged.
  - While m_valid=1 and m_ready=0, m_data and the flags are held stable.
- Latency: the first m_valid rises RD_LATENCY+2 cycles after the edge that samples frame_start.
- Throughput: with m_ready held at 1, the block delivers 1 pixel/clk with no bubbles, and a frame takes IMG_W*IMG_H + RD_LATENCY + 2 cycles.
- Overflow and underflow are impossible by construction. Assertions cover: FIFO push when full, and inflight > FIFO_DEPTH.
- frame_done pulses, busy falls, and the FSM enters IDLE on the same edge, after the m_eof handshake. A frame_start on that same cycle is ignored; one on the next cycle is accepted.

Optional Feature:
- Macro ROM_FRAME_READER_LOOP_EN.
- Defined: after the last address is issued, ISSUE rolls directly into the next frame. x, y and rom_addr reload with no gap, and frames stream back to back with m_sof following m_eof.
  - frame_done still pulses per frame and busy stays 1.
  - frame_start is needed only once after reset.
- Undefined: single-frame operation as above.

Test Plan:
- IMG_W=4, IMG_H=2, BASE_ADDR=0, RD_LATENCY=1; ROM model returns {8'hA5, addr}; m_ready=1; frame_start pulse at cycle 0 -> m_valid first high at cycle 3. Eight consecutive pixels A50000..A50007. m_sof on pixel 0, m_eol on pixels 3 and 7, m_eof on pixel 7. frame_done at cycle 11.
- Same config; m_ready=0 for 5 cycles starting at pixel 2 -> m_data holds A50002 stable; at most 3 addresses issued beyond the FIFO head; all 8 pixels delivered in order, none repeated.
- RD_LATENCY=2, BASE_ADDR=16'h0100, IMG_W=3, IMG_H=3; m_ready toggled 1/0 every cycle -> 9 pixels A50100..A50108 in order. First m_valid 4 cycles after frame_start. m_eof on A50108.
- frame_start re-pulsed while busy, mid-frame -> ignored; exactly one frame of 8 pixels and one frame_done.
- rst_n asserted at pixel 4 of a frame -> same cycle: m_valid=0, busy=0, rom_addr=BASE_ADDR. A new frame_start after release restarts at pixel (0,0) with m_sof.
- With ROM_FRAME_READER_LOOP_EN, 4x2 image, m_ready=1 -> 24 consecutive valid pixels over 3 frames with no bubble. m_sof directly follows each m_eof; frame_done pulses 3 times.
